nonsym_pattern_checker: RTL and testbench
=========================================

Name: nonsym_pattern_checker

Overview:
- Downstream consumer of the 32->64 non-symmetric write-test FIFO.
- Each valid 64-bit FIFO output word is compared against an internally generated 32-bit host pattern stream.
- Counts mismatching 32-bit lanes and beats checked; results go to host via WireOut endpoints.
- Sits between FIFO dout/valid and the okWireOut bank, in the okClk domain.

Parameters:
- DATA_W, 64, FIFO output word width; fixed at 2 x 32-bit lanes.
- ERR_W, 32, error counter width; saturating.
- CNT_W, 32, beats-checked counter width; wraps.

Ports:
- okClk  input  1  sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- pattern_sel  input  32  pattern mode from WireIn; only bits [1:0] are used; latched on restart.
- restart_pattern  input  1  one-cycle trigger; reseeds generator and relatches mode.
- clear_errors  input  1  one-cycle trigger; clears error_count and first-error capture.
- data_valid  input  1  FIFO valid; one beat per high cycle.
- data_in  input  DATA_W  beat; [63:32] is the earlier host word, [31:0] the later one.
- error_count  output  ERR_W  mismatching lanes, saturating.
- beats_checked  output  CNT_W  beats compared since restart.
- running  output  1  high in RUN state.

Behaviour:
- Async reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Generator goes to s0 of mode 0 (latched mode = 0).
- Generator produces 32-bit sequence s(n). Beat k is expected to equal {s(2k), s(2k+1)}; the generator advances by 2 per accepted beat.
- Modes (latched pattern_sel[1:0]):
  - 0 counter: s(n) = n mod 2^32.
  - 1 LFSR: s0 = 0x00000001; next = {s[30:0], s[31]^s[21]^s[1]^s[0]}.
  - 2 walking one: s(n) = 1 << (n mod 32).
  - 3 checker: s(n) = 0xAAAAAAAA for even n, 0x55555555 for odd n.
- FSM:
  - IDLE -> RUN on the first data_valid.
  - RUN holds until restart_pattern.
  - restart_pattern in any state -> IDLE, reseeds, relatches mode, zeroes beats_checked. error_count is not touched.
- Compare pipeline:
  - Cycle 0: beat accepted and lanes compared, with the result registered.
  - Cycle 1: error_count += (number of mismatching lanes, 0..2) and beats_checked += 1.
  - Latency is therefore 1 cycle from a valid beat to the updated outputs.
- Saturation: error_count stops at 2^ERR_W-1. Adding 2 at 2^ERR_W-2 yields 2^ERR_W-1.
- beats_checked wraps modulo 2^CNT_W.
- Simultaneous events:
  - restart_pattern and data_valid in the same cycle: restart wins; the beat is discarded (not counted, generator not advanced).
  - clear_errors and data_valid in the same cycle: clear wins for that beat's errors (error_count = 0 next cycle). The beat is still counted in beats_checked and still advances the generator.
  - Both triggers in the same cycle: both actions apply.
- data_valid low: no state change, generator holds.

Optional Feature:
- Macro: NONSYM_FIRST_ERR_CAPTURE_EN.
- Defined: adds outputs first_err_valid (1), first_err_beat (CNT_W), first_err_got (64), first_err_exp (64).
  - On the first mismatching beat after reset or clear_errors, the outputs capture the beat index, received word and expected word, and first_err_valid is set.
  - Later errors do not overwrite the capture.
  - Cleared by clear_errors and by reset; restart_pattern does not clear it.
- Undefined: these ports and registers are absent.

Decomposition:
- Package nonsym_pkg holds:
  - mode encodings MODE_COUNTER/MODE_LFSR/MODE_WALK/MODE_CHECKER;
  - LFSR_SEED = 32'h00000001 and LFSR tap positions;
  - CHECKER_EVEN/CHECKER_ODD constants.
- Sub-module nonsym_pattern_gen: holds the latched mode and state s(n). It outputs the lane pair {s(2k), s(2k+1)} combinationally, advances on an advance strobe, and reseeds on restart.

Test Plan:
- Counter mode: restart, then 256 beats {2k, 2k+1} for k = 0..255 -> error_count=0, beats_checked=256, running=1.
- Counter mode with beat 5 high lane sent as 0x0000000B (exp 0x0000000A) and beat 9 both lanes corrupted -> error_count=3. With NONSYM_FIRST_ERR_CAPTURE_EN: first_err_beat=5, first_err_exp=64'h0000000A_0000000B.
- LFSR mode: beats {0x00000001, 0x00000003} then {0x00000006, 0x0000000D} -> error_count=0. Sending {0x00000001, 0x00000002} as beat 0 instead -> error_count=1.
- restart_pattern asserted together with a valid beat mid-stream -> beat ignored, beats_checked=0, running=0. The next beat is compared against s0/s1.
- ERR_W=4 override: 10 beats with both lanes wrong -> error_count=15 (saturates). clear_errors -> 0 one cycle later.
- Async reset_n pulse mid-run between clock edges -> all outputs 0 immediately. After release, mode 0 beat {0, 1} -> error_count=0, beats_checked=1.

Source files
------------

// File: rtl/nonsym_pkg.sv
// -----------------------------------------------------------------------------
// nonsym_pkg
// Shared definitions for the non-symmetric FIFO pattern checker:
//   - pattern mode encodings (latched from pattern_sel[1:0])
//   - LFSR seed and tap positions
//   - checkerboard constants
//   - checker FSM state encoding
//   - helper functions: one LFSR step and the per-mode seed value
// -----------------------------------------------------------------------------
package nonsym_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [LANE_W-1:0] LFSR_SEED    = 32'h0000_0001;
  localparam int                LFSR_TAP_A   = 31;
  localparam int                LFSR_TAP_B   = 21;
  localparam int                LFSR_TAP_C   = 1;
  localparam int                LFSR_TAP_D   = 0;

  localparam logic [LANE_W-1:0] CHECKER_EVEN = 32'hAAAA_AAAA;
  localparam logic [LANE_W-1:0] CHECKER_ODD  = 32'h5555_5555;

  // Shift left by one, feedback from the four taps enters at bit 0.
  function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
    return {s[LANE_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

  // s(0) for each mode.
  function automatic logic [LANE_W-1:0] seed_of(input mode_e m);
    case (m)
      MODE_COUNTER: return '0;
      MODE_LFSR:    return LFSR_SEED;
      MODE_WALK:    return 32'h0000_0001;
      MODE_CHECKER: return CHECKER_EVEN;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/nonsym_pattern_gen.sv
// -----------------------------------------------------------------------------
// nonsym_pattern_gen
// Host pattern generator. Holds the latched mode and s(2k), the expected
// earlier host word of the next beat, and presents {s(2k), s(2k+1)}
// combinationally. Each advance moves the sequence forward by two words.
//
// Ports:
//   okClk      clock
//   reset_n    asynchronous active-low reset (mode 0, s = 0)
//   restart_i  reseed the sequence and latch mode_i
//   mode_i     pattern mode to latch on restart
//   advance_i  one accepted beat: step the sequence by two
//   lanes_o    expected beat {s(2k), s(2k+1)}
// -----------------------------------------------------------------------------
module nonsym_pattern_gen
  import nonsym_pkg::*;
(
  input  logic                okClk,
  input  logic                reset_n,
  input  logic                restart_i,
  input  mode_e               mode_i,
  input  logic                advance_i,
  output logic [2*LANE_W-1:0] lanes_o
);

  mode_e             mode_q;
  logic [LANE_W-1:0] s_q;
  logic [LANE_W-1:0] s_d;
  logic [LANE_W-1:0] s_odd;
  logic [LANE_W-1:0] s_adv;

  // s(2k+1) and s(2k+2), both derived from the stored s(2k).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s_odd = s_q;
    s_adv = s_q;
    case (mode_q)
      MODE_COUNTER: begin
        s_odd = s_q + 32'd1;
        s_adv = s_q + 32'd2;
      end
      MODE_LFSR: begin
        s_odd = lfsr_step(s_q);
        s_adv = lfsr_step(lfsr_step(s_q));
      end
      MODE_WALK: begin
        s_odd = {s_q[LANE_W-2:0], s_q[LANE_W-1]};
        s_adv = {s_q[LANE_W-3:0], s_q[LANE_W-1:LANE_W-2]};
      end
      MODE_CHECKER: begin
        s_odd = CHECKER_ODD;
        s_adv = CHECKER_EVEN;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_d = s_q;
    if (restart_i) begin
      s_d = seed_of(mode_i);
    end else if (advance_i) begin
      s_d = s_adv;
    end
  end

  assign lanes_o = {s_q, s_odd};

  always_ff @(posedge okClk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      mode_q <= MODE_COUNTER;
      s_q    <= '0;
    end else begin
      if (restart_i) begin
        mode_q <= mode_i;
      end
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/nonsym_pattern_checker.sv
// -----------------------------------------------------------------------------
// nonsym_pattern_checker
// Consumer of the 32->64 non-symmetric write-test FIFO. Every valid 64-bit
// beat is compared lane by lane against the generated host stream; the
// number of mismatching lanes (saturating) and the number of beats checked
// (wrapping) are presented to the WireOut bank one cycle after the beat.
//
// Optional build macro: NONSYM_FIRST_ERR_CAPTURE_EN adds a first-error
// capture (first_err_valid/_beat/_got/_exp).
//
// Ports:
//   okClk            clock (okClk domain)
//   reset_n          asynchronous active-low reset
//   pattern_sel      pattern mode, bits [1:0] latched on restart_pattern
//   restart_pattern  reseed generator, relatch mode, zero beats_checked, go IDLE
//   clear_errors     zero error_count (and the first-error capture)
//   data_valid       FIFO valid, one beat per high cycle
//   data_in          beat: [63:32] earlier host word, [31:0] later one
//   error_count      mismatching lanes, saturating
//   beats_checked    beats compared since restart, wrapping
//   running          FSM is in RUN
// -----------------------------------------------------------------------------
module nonsym_pattern_checker
  import nonsym_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ERR_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              okClk,
  input  logic              reset_n,
  input  logic [31:0]       pattern_sel,
  input  logic              restart_pattern,
  input  logic              clear_errors,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [ERR_W-1:0]  error_count,
  output logic [CNT_W-1:0]  beats_checked,
  output logic              running
`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
  ,
  output logic              first_err_valid,
  output logic [CNT_W-1:0]  first_err_beat,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;
  logic [CNT_W-1:0]  beats_q;
  logic [CNT_W-1:0]  beats_d;
  logic [DATA_W-1:0] exp_word;
  logic              accept;
  logic [1:0]        lane_mis;
  logic [ERR_W:0]    err_sum;
  logic              unused_sel_bits;

  assign unused_sel_bits = ^pattern_sel[31:2];

  // Restart discards a coincident beat: no compare, no count, no advance.
  assign accept = data_valid && !restart_pattern;

  nonsym_pattern_gen u_gen (
    .okClk     (okClk),
    .reset_n   (reset_n),
    .restart_i (restart_pattern),
    .mode_i    (mode_e'(pattern_sel[1:0])),
    .advance_i (accept),
    .lanes_o   (exp_word)
  );

  assign lane_mis = 2'((data_in[DATA_W-1:DATA_W/2] != exp_word[DATA_W-1:DATA_W/2]))
                  + 2'((data_in[DATA_W/2-1:0]      != exp_word[DATA_W/2-1:0]));

  // One extra bit catches the carry out; adding at most 2 to a value no
  // larger than the maximum can only overshoot into that bit.
  assign err_sum = {1'b0, err_q} + (ERR_W+1)'(lane_mis);

  always_comb begin
    state_d = state_q;
    running = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  running = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (restart_pattern) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    err_d   = err_q;
    beats_d = beats_q;
    if (accept) begin
      err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      beats_d = beats_q + CNT_W'(1);
    end
    if (restart_pattern) beats_d = '0;
    if (clear_errors)    err_d   = '0;
  end

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      beats_q <= beats_d;
    end
  end

  assign error_count   = err_q;
  assign beats_checked = beats_q;

`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
  logic              fe_valid_q;
  logic [CNT_W-1:0]  fe_beat_q;
  logic [DATA_W-1:0] fe_got_q;
  logic [DATA_W-1:0] fe_exp_q;

  // Capture only a beat whose errors actually count: a clear in the same
  // cycle wins over the capture just as it wins over error_count.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      fe_valid_q <= 1'b0;
      fe_beat_q  <= '0;
      fe_got_q   <= '0;
      fe_exp_q   <= '0;
    end else if (clear_errors) begin
      fe_valid_q <= 1'b0;
      fe_beat_q  <= '0;
      fe_got_q   <= '0;
      fe_exp_q   <= '0;
    end else if (accept && (lane_mis != 2'd0) && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_beat_q  <= beats_q;
      fe_got_q   <= data_in;
      fe_exp_q   <= exp_word;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_beat  = fe_beat_q;
  assign first_err_got   = fe_got_q;
  assign first_err_exp   = fe_exp_q;
`endif

endmodule

// File: tb/tb_nonsym_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_nonsym_pattern_checker
// Drives two checkers from the same stimulus: one with default widths and one
// with a 4-bit error counter. A behavioural model derives s(n) directly from
// n, tracks counts and state, and is compared against both DUTs on every
// falling clock edge. Directed sections pin the model with literal values;
// a randomized section follows.
// -----------------------------------------------------------------------------
module tb_nonsym_pattern_checker;

  localparam int LFSR_N = 16384;

  logic        okClk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pattern_sel = '0;
  logic        restart_pattern = 1'b0;
  logic        clear_errors = 1'b0;
  logic        data_valid = 1'b0;
  logic [63:0] data_in = '0;

  logic [31:0] error_count, beats_checked, beats4;
  logic [3:0]  error4;
  logic        running, running4;

`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
  logic        fe_valid, fe_valid4;
  logic [31:0] fe_beat, fe_beat4;
  logic [63:0] fe_got, fe_got4, fe_exp, fe_exp4;
`endif

  always #5 okClk = ~okClk;

  nonsym_pattern_checker dut (
    .okClk(okClk), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .restart_pattern(restart_pattern), .clear_errors(clear_errors),
    .data_valid(data_valid), .data_in(data_in),
    .error_count(error_count), .beats_checked(beats_checked), .running(running)
`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fe_valid), .first_err_beat(fe_beat),
    .first_err_got(fe_got), .first_err_exp(fe_exp)
`endif
  );

  nonsym_pattern_checker #(.ERR_W(4)) dut4 (
    .okClk(okClk), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .restart_pattern(restart_pattern), .clear_errors(clear_errors),
    .data_valid(data_valid), .data_in(data_in),
    .error_count(error4), .beats_checked(beats4), .running(running4)
`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fe_valid4), .first_err_beat(fe_beat4),
    .first_err_got(fe_got4), .first_err_exp(fe_exp4)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] lfsr_tab[LFSR_N];

  initial begin
    lfsr_tab[0] = 32'h1;
    for (int i = 1; i < LFSR_N; i++) begin
      bit [31:0] p;
      p = lfsr_tab[i-1];
      lfsr_tab[i] = {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
    end
  end

  function automatic bit [31:0] s_of(input bit [1:0] mode, input int unsigned n);
    case (mode)
      2'd0: return n;
      2'd1: return (n < LFSR_N) ? lfsr_tab[n] : 32'h0;
      2'd2: return 32'h1 << (n % 32);
      default: return (n % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  bit [1:0]    m_mode;
  int unsigned m_n;      // index of the next expected host word
  longint      m_err, m_err4;
  bit [31:0]   m_beats;
  bit          m_run;
  bit          m_fe_valid;
  bit [31:0]   m_fe_beat;
  bit [63:0]   m_fe_got, m_fe_exp;
  bit [63:0]   m_e;
  int          m_mm;

  function automatic bit [63:0] model_exp();
    return {s_of(m_mode, m_n), s_of(m_mode, m_n + 1)};
  endfunction

  always @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_n = 0; m_err = 0; m_err4 = 0; m_beats = 0; m_run = 0;
      m_fe_valid = 0; m_fe_beat = 0; m_fe_got = 0; m_fe_exp = 0;
    end else begin
      if (restart_pattern) begin
        m_mode = pattern_sel[1:0]; m_n = 0; m_beats = 0; m_run = 0;
      end else if (data_valid) begin
        m_e  = model_exp();
        m_mm = int'(data_in[63:32] != m_e[63:32]) + int'(data_in[31:0] != m_e[31:0]);
        if (!clear_errors) begin
          m_err  = (m_err + m_mm > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + m_mm;
          m_err4 = (m_err4 + m_mm > 15) ? 15 : m_err4 + m_mm;
          if (m_mm != 0 && !m_fe_valid) begin
            m_fe_valid = 1; m_fe_beat = m_beats; m_fe_got = data_in; m_fe_exp = m_e;
          end
        end
        m_n += 2; m_beats++; m_run = 1;
      end
      if (clear_errors) begin
        m_err = 0; m_err4 = 0;
        m_fe_valid = 0; m_fe_beat = 0; m_fe_got = 0; m_fe_exp = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge okClk) begin
    check("error_count", 64'(error_count), 64'(m_err));
    check("error_count_w4", 64'(error4), 64'(m_err4));
    check("beats_checked", 64'(beats_checked), 64'(m_beats));
    check("beats_checked_w4", 64'(beats4), 64'(m_beats));
    check("running", 64'(running), 64'(m_run));
    check("running_w4", 64'(running4), 64'(m_run));
`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
    check("first_err_valid", 64'(fe_valid), 64'(m_fe_valid));
    check("first_err_beat", 64'(fe_beat), 64'(m_fe_beat));
    check("first_err_got", fe_got, m_fe_got);
    check("first_err_exp", fe_exp, m_fe_exp);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    data_valid = 1'b1; data_in = d;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic restart(input logic [31:0] sel);
    pattern_sel = sel; restart_pattern = 1'b1;
    tick();
    restart_pattern = 1'b0;
  endtask

  task automatic clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  initial begin
    bit [63:0] d;
    int        lane;

    // Reset state.
    repeat (2) tick();
    check("reset error_count", 64'(error_count), 64'd0);
    check("reset beats_checked", 64'(beats_checked), 64'd0);
    check("reset running", 64'(running), 64'd0);
    reset_n = 1'b1;
    tick();

    // Counter mode: 256 clean beats.
    restart(32'd0);
    for (int k = 0; k < 256; k++) beat({32'(2*k), 32'(2*k+1)});
    check("counter error_count", 64'(error_count), 64'd0);
    check("counter beats_checked", 64'(beats_checked), 64'd256);
    check("counter running", 64'(running), 64'd1);

    // Counter mode with a single-lane error at beat 5 and a double at beat 9.
    restart(32'd0);
    clear();
    for (int k = 0; k < 10; k++) begin
      d = {32'(2*k), 32'(2*k+1)};
      if (k == 5) d[63:32] = 32'h0000_000B;
      if (k == 9) d = ~d;
      beat(d);
    end
    check("counter errors", 64'(error_count), 64'd3);
`ifdef NONSYM_FIRST_ERR_CAPTURE_EN
    check("first_err_beat lit", 64'(fe_beat), 64'd5);
    check("first_err_exp lit", fe_exp, 64'h0000000A_0000000B);
    check("first_err_got lit", fe_got, 64'h0000000B_0000000B);
`endif

    // LFSR mode.
    clear();
    restart(32'd1);
    beat({32'h0000_0001, 32'h0000_0003});
    beat({32'h0000_0006, 32'h0000_000D});
    check("lfsr clean", 64'(error_count), 64'd0);
    restart(32'hFFFF_FFF5);   // only bits [1:0] = 1 matter
    beat({32'h0000_0001, 32'h0000_0002});
    check("lfsr one lane", 64'(error_count), 64'd1);

    // Restart coincident with a valid beat mid-stream.
    clear();
    restart(32'd0);
    for (int k = 0; k < 4; k++) beat({32'(2*k), 32'(2*k+1)});
    data_valid = 1'b1; data_in = 64'hDEAD_BEEF_0BAD_F00D;
    pattern_sel = 32'd0; restart_pattern = 1'b1;
    tick();
    restart_pattern = 1'b0; data_valid = 1'b0;
    check("restart+valid beats", 64'(beats_checked), 64'd0);
    check("restart+valid running", 64'(running), 64'd0);
    beat({32'd0, 32'd1});
    check("post-restart errors", 64'(error_count), 64'd0);
    check("post-restart beats", 64'(beats_checked), 64'd1);

    // Saturation of the 4-bit counter, then clear.
    clear();
    restart(32'd0);
    for (int k = 0; k < 10; k++) beat(~{32'(2*k), 32'(2*k+1)});
    check("w4 saturated", 64'(error4), 64'd15);
    check("w32 not saturated", 64'(error_count), 64'd20);
    clear();
    check("w4 cleared", 64'(error4), 64'd0);

    // Walking-one and checker spot checks.
    restart(32'd2);
    beat({32'h0000_0001, 32'h0000_0002});
    beat({32'h0000_0004, 32'h0000_0008});
    restart(32'd3);
    beat({32'hAAAA_AAAA, 32'h5555_5555});
    check("walk+checker clean", 64'(error_count), 64'd0);

    // Asynchronous reset pulse between clock edges.
    restart(32'd1);
    beat(64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst error_count", 64'(error_count), 64'd0);
    check("async rst beats", 64'(beats_checked), 64'd0);
    check("async rst running", 64'(running), 64'd0);
    #3 reset_n = 1'b1;
    tick();
    beat({32'd0, 32'd1});
    check("post-reset errors", 64'(error_count), 64'd0);
    check("post-reset beats", 64'(beats_checked), 64'd1);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 2500; c++) begin
      restart_pattern = ($urandom_range(0, 199) == 0) || (m_n > 12000);
      pattern_sel     = $urandom;
      clear_errors    = ($urandom_range(0, 149) == 0);
      data_valid      = ($urandom_range(0, 9) < 7);
      d = model_exp();
      if ($urandom_range(0, 9) == 0) begin
        lane = $urandom_range(0, 2);
        if (lane != 1) d[31:0]  = d[31:0]  ^ ($urandom | 32'h1);
        if (lane != 0) d[63:32] = d[63:32] ^ ($urandom | 32'h1);
      end
      data_in = d;
      tick();
    end
    restart_pattern = 1'b0; clear_errors = 1'b0; data_valid = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
